mul_hilo_unit: RTL and testbench
================================

Name: mul_hilo_unit

Overview:
- Multi-cycle shift-and-add multiplier for MULT/MULTU, with the architectural HI/LO register pair.
- Sits beside the barrel shifter in the EX stage and takes the same register-file operands (rs, rt).
- Feeds HI/LO into the writeback result mux for MFHI/MFLO.
- Asserts busy so the control unit stalls the PC while a product is being formed.

Parameters:
- WIDTH, 32, operand width. The product is 2*WIDTH.
- CNT_W, 6, iteration counter width. It must hold WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a multiply. Sampled only when not busy.
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU. Sampled with start.
- op_a  in  WIDTH  multiplicand (rs).
- op_b  in  WIDTH  multiplier (rt).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  multiply in progress. Used as the stall request.
- done  out  1  one-cycle pulse: HI/LO just updated by a multiply.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, active-high, may occur at any time):
  - state=IDLE.
  - hi, lo, internal accumulator, multiplicand, multiplier and counter all 0.
  - busy=0, done=0.
  - An in-flight multiply is discarded; HI/LO are not updated.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 → RUN. Latch sign_neg = is_signed & (op_a[31]^op_b[31]). Latch |op_a| and |op_b| (absolute value only when is_signed), clear the accumulator, cnt=0.
  - RUN: each edge, if multiplier[0]=1 add the zero-extended multiplicand into the upper half of the 65-bit accumulator. Then shift {carry,acc} right one bit, shift the multiplier right one bit, cnt++.
  - RUN, edge with cnt==WIDTH-1 → DONE. At that edge {hi,lo} = sign_neg ? -(acc) : acc, taken mod 2^64.
  - DONE: done=1 for exactly this cycle, then IDLE. start=1 in DONE is accepted the same as in IDLE (back-to-back issue, no idle bubble).
- Output timing:
  - busy=1 exactly while in RUN, combinational from state.
  - done is a registered state decode.
- Latency: start at edge 0 → hi/lo valid and done=1 after edge WIDTH+1 (edge 33 at WIDTH=32).
- start while in RUN is ignored. The operands are not re-sampled.
- MTHI/MTLO:
  - Outside RUN, hi_we/lo_we write wdata into hi/lo at the edge.
  - In RUN the writes are ignored.
  - If a write coincides with the RUN→DONE edge, the product wins.
  - hi_we and lo_we together write both registers.
- Special case: MULT of 0x80000000 by itself. |op| = 0x80000000, which is correct as unsigned, so the result is 0x40000000_00000000.
- hi/lo keep their values indefinitely between operations.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined: RUN also goes to DONE at any edge where the shifted multiplier becomes 0.
  - The accumulator is right-aligned at that point by shifting the remaining WIDTH-1-cnt positions in the final write. A single barrel-shift stage is allowed for this.
  - Minimum one RUN cycle, so op_b=0 completes with done after edge 2.
- Not defined: fixed WIDTH RUN cycles.
- Results are bit-identical in both builds; only latency differs.

Decomposition:
- Package mul_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), WIDTH/CNT_W defaults, product-width constant.
- One sub-module, mul_negate64: combinational 64-bit conditional two's-complement negate (neg, in, out). Used for the final sign fix.
- Operand absolute value is done inline.

Test Plan:
- MULTU 7 × 6, start one cycle → busy for 32 cycles, done after edge 33, hi=0x00000000, lo=0x0000002A. With MUL_EARLY_EXIT_EN: done after edge 4.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. MULT on the same operands → hi=0x00000000, lo=0x00000001.
- MULT -3 × 5 (0xFFFFFFFD, 0x00000005) → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000.
- Assert rst at RUN cycle 10 of 7 × 6 → busy=0, hi=lo=0 immediately (asynchronously). No done pulse. A following start of 2 × 3 gives lo=6.
- Pulse start again at RUN cycle 5 with different operands → ignored, original product returned. start held high through DONE → second multiply begins with no idle cycle.
- hi_we in IDLE with wdata=0x12345678 → hi=0x12345678 next cycle. lo_we during RUN → lo unchanged. lo_we on the completion edge → lo = product.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and default sizes for the shift-and-add HI/LO multiplier.
package mul_pkg;
    localparam int MUL_WIDTH  = 32;
    localparam int MUL_CNT_W  = 6;
    localparam int MUL_PROD_W = 2 * MUL_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mul_negate64.sv
// Conditional two's-complement negate applied to the final unsigned product.
module mul_negate64
    import mul_pkg::*;
#(
    parameter int W = MUL_PROD_W
) (
    input  logic         neg,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    // Pass through or negate modulo 2^W.
    always_comb begin
        if (neg) begin
            out = {W{1'b0}} - in;
        end else begin
            out = in;
        end
    end

endmodule

// File: rtl/mul_hilo_unit.sv
// MULT/MULTU shift-and-add multiplier with architectural HI/LO registers.
// Optional build macro MUL_EARLY_EXIT_EN ends RUN once the multiplier runs out of set bits.
module mul_hilo_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t               state_r;
    logic                 done_r;
    logic                 sign_neg_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [CNT_W-1:0]     cnt_r;

    logic [WIDTH-1:0]     abs_a_s;
    logic [WIDTH-1:0]     abs_b_s;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH-1:0]   acc_next_s;
    logic [WIDTH-1:0]     mplier_next_s;
    logic                 finish_s;
    logic [2*WIDTH-1:0]   aligned_s;
    logic [2*WIDTH-1:0]   prod_s;

    // Operand magnitudes; 0x80000000 stays 0x80000000, which is right as unsigned.
    always_comb begin
        if (is_signed && op_a[WIDTH-1]) begin
            abs_a_s = {WIDTH{1'b0}} - op_a;
        end else begin
            abs_a_s = op_a;
        end
        if (is_signed && op_b[WIDTH-1]) begin
            abs_b_s = {WIDTH{1'b0}} - op_b;
        end else begin
            abs_b_s = op_b;
        end
    end

    // One iteration: conditional add into the upper half, then shift {carry,acc} right.
    always_comb begin
        sum_s         = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                      + ({1'b0, mcand_r} & {(WIDTH+1){mplier_r[0]}});
        acc_next_s    = {sum_s, acc_r[WIDTH-1:1]};
        mplier_next_s = mplier_r >> 1;
`ifdef MUL_EARLY_EXIT_EN
        finish_s      = (cnt_r == CNT_W'(WIDTH-1)) || (mplier_next_s == {WIDTH{1'b0}});
        aligned_s     = acc_next_s >> (CNT_W'(WIDTH-1) - cnt_r);
`else
        finish_s      = (cnt_r == CNT_W'(WIDTH-1));
        aligned_s     = acc_next_s;
`endif
    end

    mul_negate64 #(
        .W(2*WIDTH)
    ) u_negate (
        .neg(sign_neg_r),
        .in (aligned_s),
        .out(prod_s)
    );

    // Control FSM, datapath registers and HI/LO; DONE accepts a new start like IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            done_r     <= 1'b0;
            sign_neg_r <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            mcand_r    <= {WIDTH{1'b0}};
            mplier_r   <= {WIDTH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (hi_we) begin
                        hi_r <= wdata;
                    end
                    if (lo_we) begin
                        lo_r <= wdata;
                    end
                    if (start) begin
                        state_r    <= RUN;
                        sign_neg_r <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        mcand_r    <= abs_a_s;
                        mplier_r   <= abs_b_s;
                        acc_r      <= {(2*WIDTH){1'b0}};
                        cnt_r      <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    acc_r    <= acc_next_s;
                    mplier_r <= mplier_next_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (finish_s) begin
                        state_r      <= DONE;
                        done_r       <= 1'b1;
                        {hi_r, lo_r} <= prod_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_r == RUN);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Scoreboard bench for mul_hilo_unit: directed vectors, monitor checks HI/LO on every done pulse.
module tb_mul_hilo_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    mul_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .is_signed(is_signed),
        .op_a     (op_a),
        .op_b     (op_b),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected product.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("done_hi", {32'd0, hi}, {32'd0, e.hi});
                chk("done_lo", {32'd0, lo}, {32'd0, e.lo});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        start     = 1'b1;
        op_a      = a;
        op_b      = b;
        is_signed = s;
        tick();
        start = 1'b0;
    endtask

    task automatic mul_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        sb_q.push_back(e);
        issue(a, b, s);
        wait_done(name);
        tick();
    endtask

    initial begin
        int   nbusy;
        exp_t e;

        // Reset state
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;
        tick();

        // MULTU 7 x 6 with busy-length measurement
        e.hi = 32'h0000_0000; e.lo = 32'h0000_002A;
        sb_q.push_back(e);
        issue(32'd7, 32'd6, 1'b0);
        nbusy = 0;
        while (!done && nbusy < 200) begin
            if (busy) nbusy++;
            tick();
        end
        chk("busy_cycles", 64'(nbusy), 64'd32);
        chk("busy_in_done", {63'd0, busy}, 64'd0);
        tick();
        chk("done_one_cycle", {63'd0, done}, 64'd0);

        mul_op("multu_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        mul_op("mult_ff",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001);
        mul_op("mult_m3x5", 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        mul_op("mult_min",  32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);

        // Asynchronous reset in the middle of a multiply
        issue(32'd7, 32'd6, 1'b0);
        repeat (9) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_hi", {32'd0, hi}, 64'd0);
        chk("arst_lo", {32'd0, lo}, 64'd0);
        tick();
        #2;
        rst = 1'b0;
        tick();
        mul_op("after_rst", 32'd2, 32'd3, 1'b0, 32'd0, 32'd6);

        // start pulsed mid-run with other operands is ignored
        e.hi = 32'd0; e.lo = 32'd99;
        sb_q.push_back(e);
        issue(32'd9, 32'd11, 1'b0);
        repeat (4) tick();
        issue(32'hFFFF_FFF0, 32'd100, 1'b1);
        wait_done("ignored_start");
        tick();
        chk("idle_after_ignored", {63'd0, busy}, 64'd0);

        // start held through DONE: second op starts with no idle cycle
        e.hi = 32'd0; e.lo = 32'd20;
        sb_q.push_back(e);
        start = 1'b1; op_a = 32'd4; op_b = 32'd5; is_signed = 1'b0;
        tick();
        wait_done("b2b_first");
        op_a = 32'd6; op_b = 32'd7;
        e.hi = 32'd0; e.lo = 32'd42;
        sb_q.push_back(e);
        tick();
        start = 1'b0;
        chk("b2b_no_bubble", {63'd0, busy}, 64'd1);
        wait_done("b2b_second");
        tick();

        // MTHI / MTLO outside RUN
        hi_we = 1'b1; wdata = 32'h1234_5678;
        tick();
        hi_we = 1'b0;
        chk("mthi_hi", {32'd0, hi}, {32'd0, 32'h1234_5678});
        chk("mthi_lo_kept", {32'd0, lo}, {32'd0, 32'd42});
        lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        tick();
        lo_we = 1'b0;
        chk("mtlo_lo", {32'd0, lo}, {32'd0, 32'hCAFE_F00D});
        chk("mtlo_hi_kept", {32'd0, hi}, {32'd0, 32'h1234_5678});
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0F0F_0F0F;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mt_both", {hi, lo}, {32'h0F0F_0F0F, 32'h0F0F_0F0F});

        // lo_we held during RUN is ignored; on the completion edge the product wins
        e.hi = 32'd0; e.lo = 32'd9;
        sb_q.push_back(e);
        issue(32'd3, 32'd3, 1'b0);
        lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        repeat (3) tick();
        chk("mtlo_in_run", {32'd0, lo}, {32'd0, 32'h0F0F_0F0F});
        wait_done("mtlo_collide");
        lo_we = 1'b0;
        tick();
        chk("lo_holds", {32'd0, lo}, {32'd0, 32'd9});

        repeat (3) tick();
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
